// File: rtl/dom_and_scheduler.sv
// Round-robin scheduler sharing one registered-input DOM AND gadget between
// several masked requesters. Each issue consumes exactly one PRNG word, and a
// one-hot tag travels alongside the gadget pipeline to route the result back.
module dom_and_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int SHARES    = 6,
  parameter int RAND_BITS = 15,
  parameter int LATENCY   = 2,
  parameter int CNT_W     = 16
) (
  input  logic                        clock_0,
  input  logic                        reset_0,
  input  logic                        en,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*SHARES-1:0]   req_a,
  input  logic [NUM_REQ*SHARES-1:0]   req_b,
  input  logic                        rnd_valid,
  input  logic [RAND_BITS-1:0]        rnd_data,
  output logic                        rnd_ready,
  output logic [SHARES-1:0]           g_i0,
  output logic [SHARES-1:0]           g_i1,
  output logic [RAND_BITS-1:0]        g_rand,
  input  logic [SHARES-1:0]           g_o,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [SHARES-1:0]           rsp_data,
  output logic                        idle,
  output logic [CNT_W-1:0]            issue_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]                 r_ptr;
  logic [CNT_W-1:0]                 r_cnt;
  logic [SHARES-1:0]                r_i0;
  logic [SHARES-1:0]                r_i1;
  logic [RAND_BITS-1:0]             r_rand;
  logic [LATENCY:0]                 r_tag_v;
  logic [LATENCY:0][NUM_REQ-1:0]    r_tag;

  logic                             w_issue;
  logic [NUM_REQ-1:0]               w_grant_oh;
  logic [PTR_W-1:0]                 w_grant_idx;
  logic [PTR_W-1:0]                 w_ptr_next;
  logic [SHARES-1:0]                w_sel_a;
  logic [SHARES-1:0]                w_sel_b;

  // Issue only when a fresh random word and at least one request coincide.
  always_comb begin
    w_issue   = en & rnd_valid & (|req_valid);
    rnd_ready = w_issue;
    req_ready = w_issue ? w_grant_oh : '0;
  end

  // Round-robin search starting at the pointer, wrapping past the top index.
  always_comb begin : p_grant
    int unsigned idx;
    logic        found;
    w_grant_oh  = '0;
    w_grant_idx = '0;
    found       = 1'b0;
    idx         = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (int'(r_ptr) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found           = 1'b1;
        w_grant_oh[idx] = 1'b1;
        w_grant_idx     = PTR_W'(idx);
      end
    end
  end

  // Pointer advances to one past the winner, wrapping at NUM_REQ.
  always_comb begin
    if (w_grant_idx == PTR_W'(NUM_REQ - 1)) w_ptr_next = '0;
    else                                    w_ptr_next = w_grant_idx + PTR_W'(1);
  end

  // AND-OR mux gated by the one-hot grant so unselected shares are forced to zero.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_sel_a = w_sel_a | (req_a[k*SHARES +: SHARES] & {SHARES{w_grant_oh[k]}});
      w_sel_b = w_sel_b | (req_b[k*SHARES +: SHARES] & {SHARES{w_grant_oh[k]}});
    end
  end

  // Operand stage: load winner's shares and the consumed word, otherwise a zero sharing.
  always_ff @(posedge clock_0) begin
    if (reset_0) begin
      r_i0   <= '0;
      r_i1   <= '0;
      r_rand <= '0;
    end else if (w_issue) begin
      r_i0   <= w_sel_a;
      r_i1   <= w_sel_b;
      r_rand <= rnd_data;
    end else begin
      r_i0   <= '0;
      r_i1   <= '0;
      r_rand <= '0;
    end
  end

  // Pointer and issue counter bookkeeping.
  always_ff @(posedge clock_0) begin
    if (reset_0) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_issue) begin
      r_ptr <= w_ptr_next;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Tag pipeline: stage 0 is aligned with the operand registers, the last stage with g_o.
  always_ff @(posedge clock_0) begin
    if (reset_0) begin
      r_tag_v <= '0;
      r_tag   <= '0;
    end else begin
      r_tag_v[0] <= w_issue;
      r_tag[0]   <= w_issue ? w_grant_oh : '0;
      for (int unsigned s = 1; s <= LATENCY; s++) begin
        r_tag_v[s] <= r_tag_v[s-1];
        r_tag[s]   <= r_tag[s-1];
      end
    end
  end

  // Output drive.
  always_comb begin
    g_i0      = r_i0;
    g_i1      = r_i1;
    g_rand    = r_rand;
    rsp_valid = r_tag_v[LATENCY] ? r_tag[LATENCY] : '0;
    rsp_data  = g_o;
    idle      = ~(|r_tag_v);
    issue_cnt = r_cnt;
  end

endmodule

// File: tb/tb_dom_and_scheduler.sv
// Bench for dom_and_scheduler: directed phases followed by random traffic,
// checked against a transaction-level model (grant search, issue queue with
// due cycles) and a behavioural 2-stage gadget that produces real output shares.
module tb_dom_and_scheduler;
  localparam int N  = 4;
  localparam int S  = 6;
  localparam int RB = 15;
  localparam int L  = 2;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*S-1:0]  req_a;
  logic [N*S-1:0]  req_b;
  logic            rnd_valid;
  logic [RB-1:0]   rnd_data;
  logic            rnd_ready;
  logic [S-1:0]    g_i0;
  logic [S-1:0]    g_i1;
  logic [RB-1:0]   g_rand;
  logic [S-1:0]    g_o;
  logic [N-1:0]    rsp_valid;
  logic [S-1:0]    rsp_data;
  logic            idle;
  logic [CW-1:0]   issue_cnt;

  always #5 clk = ~clk;

  dom_and_scheduler #(
    .NUM_REQ(N), .SHARES(S), .RAND_BITS(RB), .LATENCY(L), .CNT_W(CW)
  ) dut (
    .clock_0(clk), .reset_0(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready),
    .g_i0(g_i0), .g_i1(g_i1), .g_rand(g_rand), .g_o(g_o),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .idle(idle), .issue_cnt(issue_cnt)
  );

  // Behavioural gadget: output shares are a fresh sharing of (^a)&(^b).
  function automatic logic [S-1:0] gadget(input logic [S-1:0] a, input logic [S-1:0] b,
                                          input logic [RB-1:0] r);
    logic [S-1:0] s;
    s[S-2:0] = r[S-2:0];
    s[S-1]   = ((^a) & (^b)) ^ (^r[S-2:0]);
    return s;
  endfunction

  logic [S-1:0] gs1, gs2;
  always @(posedge clk) begin
    gs1 <= gadget(g_i0, g_i1, g_rand);
    gs2 <= gs1;
  end
  assign g_o = gs2;

  // Reference model state.
  typedef struct { int due; int k; bit prod; } rsp_t;
  rsp_t          pend[$];
  int            ptr, cnt, cyc;
  logic [S-1:0]  e_i0, e_i1;
  logic [RB-1:0] e_rnd;
  int            n_checks = 0;
  int            n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) begin
      req_a[k*S +: S] = S'($urandom);
      req_b[k*S +: S] = S'($urandom);
    end
    rnd_data = RB'($urandom);
  endtask

  // Give requester k operand shares unmasking to pa / pb.
  task automatic set_parity(input int k, input bit pa, input bit pb);
    logic [S-1:0] a, b;
    a = S'($urandom);
    b = S'($urandom);
    if ((^a) != pa) a[0] = ~a[0];
    if ((^b) != pb) b[0] = ~b[0];
    req_a[k*S +: S] = a;
    req_b[k*S +: S] = b;
  endtask

  // One cycle: check outputs against the model, clock, then advance the model.
  task automatic step();
    bit           iss;
    int           k;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    bit           prod;
    #3;
    k = 0;
    iss = en && rnd_valid && (req_valid != '0);
    if (iss) begin
      for (int i = N - 1; i >= 0; i--)
        if (req_valid[(ptr + i) % N]) k = (ptr + i) % N;
    end
    exp_rdy = iss ? N'(1 << k) : '0;
    prod = (^req_a[k*S +: S]) & (^req_b[k*S +: S]);
    if (!rst) begin
      exp_rv = (pend.size() > 0 && pend[0].due == cyc) ? N'(1 << pend[0].k) : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rnd_ready", 32'(rnd_ready), 32'(iss));
      chk("g_i0", 32'(g_i0), 32'(e_i0));
      chk("g_i1", 32'(g_i1), 32'(e_i1));
      chk("g_rand", 32'(g_rand), 32'(e_rnd));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("idle", 32'(idle), 32'(pend.size() == 0));
      chk("issue_cnt", 32'(issue_cnt), 32'(cnt));
      if (exp_rv != '0) chk("rsp_xor", 32'(^rsp_data), 32'(pend[0].prod));
    end
    @(posedge clk);
    if (rst) begin
      pend.delete();
      ptr = 0; cnt = 0;
      e_i0 = '0; e_i1 = '0; e_rnd = '0;
    end else if (iss) begin
      e_i0  = req_a[k*S +: S];
      e_i1  = req_b[k*S +: S];
      e_rnd = rnd_data;
      pend.push_back('{cyc + 1 + L, k, prod});
      ptr = (k + 1) % N;
      cnt = (cnt + 1) % (1 << CW);
    end else begin
      e_i0 = '0; e_i1 = '0; e_rnd = '0;
    end
    cyc++;
    while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req_valid = '0; rnd_valid = 1'b0;
    req_a = '0; req_b = '0; rnd_data = '0;
    cyc = 0; ptr = 0; cnt = 0; e_i0 = '0; e_i1 = '0; e_rnd = '0;
    @(posedge clk); #1;
    step(); step();
    rst = 1'b0;

    // Single op from requester 2: 1&1, then 1&0.
    step(); step(); step();
    en = 1'b1; rnd_valid = 1'b1; rand_data();
    req_valid = 4'b0100; set_parity(2, 1'b1, 1'b1);
    step();
    req_valid = '0; rand_data();
    repeat (4) step();
    req_valid = 4'b0100; set_parity(2, 1'b1, 1'b0);
    step();
    req_valid = '0;
    repeat (4) step();

    // Round-robin with all requesters asserted.
    req_valid = 4'b1111;
    repeat (8) begin rand_data(); step(); end
    req_valid = '0;
    repeat (4) step();

    // Randomness stall, then release.
    req_valid = 4'b1010; rnd_valid = 1'b0;
    repeat (4) begin rand_data(); step(); end
    rnd_valid = 1'b1; rand_data(); step();
    req_valid = '0;
    repeat (4) step();

    // Drain after en drops.
    req_valid = 4'b1111;
    repeat (3) begin rand_data(); step(); end
    en = 1'b0;
    repeat (6) begin rand_data(); step(); end

    // Reset with two operations in flight.
    en = 1'b1;
    repeat (2) begin rand_data(); step(); end
    rst = 1'b1; step();
    rst = 1'b0; req_valid = '0;
    repeat (5) step();

    // Counter wrap: 17 issues with a 4-bit counter.
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 4'b1111;
    repeat (17) begin rand_data(); step(); end
    req_valid = '0;
    #3;
    chk("cnt_wrap", 32'(issue_cnt), 32'd1);
    #1;
    step();
    repeat (4) step();

    // Random traffic.
    repeat (400) begin
      rand_data();
      en        = ($urandom_range(0, 9) != 0);
      rnd_valid = ($urandom_range(0, 3) != 0);
      req_valid = N'($urandom);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; en = 1'b0; req_valid = '0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
